// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM states, RV load/store funct3 codes,
// fault cause codes and mem_ctrl bit positions (also used by EX/MEM and decode).
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam int MC_WRITE    = 5;
  localparam int MC_READ     = 4;
  localparam int MC_RSVD     = 3;
  localparam int MC_TYPE_MSB = 2;
  localparam int MC_TYPE_LSB = 0;

  // funct3 encodings that are not a load or store width at all
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid/rdata response phase.
// master = the access unit, slave = the memory side.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data, load
// extraction/extension, and the misaligned / illegal access checks.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // store lanes: width comes from funct3[1:0], lane from the low address bits
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (type_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  // load extraction and sign/zero extension
  always_comb begin
    ld_byte = 8'h00;
    case (addr_lo_i)
      2'd0: ld_byte = load_raw_i[7:0];
      2'd1: ld_byte = load_raw_i[15:8];
      2'd2: ld_byte = load_raw_i[23:16];
      default: ld_byte = load_raw_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];
    case (type_i)
      F3_LB:   load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_data_o = {24'h0, ld_byte};
      F3_LHU:  load_data_o = {16'h0, ld_half};
      default: load_data_o = load_raw_i;
    endcase
  end

  // access legality; illegal takes priority over misalignment in the caller
  always_comb begin
    illegal_o    = (mem_read_i & mem_write_i) | f3_illegal(type_i);
    misaligned_o = ((type_i[1:0] == 2'b01) & addr_lo_i[0]) |
                   ((type_i[1:0] == 2'b10) & (addr_lo_i != 2'b00));
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM control, address and store data into
// one outstanding data-memory transaction and returns extended load data.
// Optional feature macro: MEM_TIMEOUT_EN adds a bus-wait timeout (TIMEOUT_CYCLES).
//
// state     | meaning
// ST_IDLE   | no access in flight; legality checked, new access accepted
// ST_REQ    | req held high until gnt
// ST_WAIT_R | load granted, waiting for rvalid
module mem_access_unit
  import riscv_mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     valid_i,
  input  logic [5:0]               mem_ctrl_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              store_data_i,
  output logic                     stall_o,
  output logic [31:0]              load_data_o,
  output logic                     load_valid_o,
  output logic                     fault_o,
  output logic [1:0]               fault_cause_o,
  mem_access_unit_if.master        dmem
);

  mem_state_e  state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        mem_rd, mem_wr, access, reject;
  logic [2:0]  al_type;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_misaligned, al_illegal;
  logic        unused_rsvd;

  assign mem_rd      = mem_ctrl_i[MC_READ];
  assign mem_wr      = mem_ctrl_i[MC_WRITE];
  assign unused_rsvd = mem_ctrl_i[MC_RSVD];
  assign access      = valid_i & (mem_rd | mem_wr);
  assign reject      = al_illegal | al_misaligned;

  // IDLE looks at the live instruction; in flight we extract with latched info
  assign al_type = (state_q == ST_IDLE) ? mem_ctrl_i[MC_TYPE_MSB:MC_TYPE_LSB] : type_q;
  assign al_lo   = (state_q == ST_IDLE) ? addr_i[1:0] : alo_q;

  lsu_align u_align (
    .type_i       (al_type),
    .addr_lo_i    (al_lo),
    .mem_read_i   (mem_rd),
    .mem_write_i  (mem_wr),
    .store_data_i (store_data_i),
    .load_raw_i   (dmem.rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_ld_data),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    alo_d      = alo_q;
    we_d       = we_q;
    req_d      = req_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    fault_d    = 1'b0;
    cause_d    = cause_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (al_illegal) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (al_misaligned) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_REQ;
            type_d  = mem_ctrl_i[MC_TYPE_MSB:MC_TYPE_LSB];
            alo_d   = addr_i[1:0];
            we_d    = mem_wr;
            req_d   = 1'b1;
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (dmem.gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ST_IDLE;
          end else if (dmem.rvalid) begin
            state_d    = ST_IDLE;
            ld_data_d  = al_ld_data;
            ld_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT_R;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_WAIT_R: begin
        if (dmem.rvalid) begin
          state_d    = ST_IDLE;
          ld_data_d  = al_ld_data;
          ld_valid_d = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      type_q     <= 3'b000;
      alo_q      <= 2'b00;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      ld_data_q  <= 32'h0;
      ld_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      alo_q      <= alo_d;
      we_q       <= we_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign stall_o       = (state_q != ST_IDLE) | (access & ~reject);
  assign load_data_o   = ld_data_q;
  assign load_valid_o  = ld_valid_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign dmem.req      = req_q;
  assign dmem.we       = we_q;
  assign dmem.addr     = addr_q;
  assign dmem.be       = be_q;
  assign dmem.wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses checked
// against an arithmetic model of lanes, extension, legality and latency.
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int MAXG = 3;
  localparam int MAXR = 4;
`else
  localparam int MAXG = 6;
  localparam int MAXR = 6;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_i;
  logic [5:0]  mem_ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;

  mem_access_unit_if dmem ();

`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_unit dut (
`endif
    .CLK           (CLK),
    .RESET         (RESET),
    .valid_i       (valid_i),
    .mem_ctrl_i    (mem_ctrl_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .stall_o       (stall_o),
    .load_data_o   (load_data_o),
    .load_valid_o  (load_valid_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .dmem          (dmem)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_cause(bit rd, bit wr, int t, int unsigned a);
    if (rd && wr) return 2;
    if (t == 3 || t == 6 || t == 7) return 2;
    if ((t == 1 || t == 5) && (a % 2 != 0)) return 1;
    if (t == 2 && (a % 4 != 0)) return 1;
    return 0;
  endfunction

  function automatic int nbytes(int t);
    if (t % 4 == 0) return 1;
    if (t % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(int t, int unsigned a);
    int n = nbytes(t);
    int lane = ((a % 4) / n) * n;
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(int t, logic [31:0] d);
    int n = nbytes(t);
    if (n == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(int t, int unsigned a, logic [31:0] raw);
    int n = nbytes(t);
    longint unsigned v = longint'(raw) >> (8 * (a % 4));
    longint unsigned lim = 64'd1 << (8 * n);
    if (n == 4) return raw;
    v = v % lim;
    if (t < 4 && v >= lim / 2) v = v + (64'hFFFF_FFFF_FFFF_FFFF - lim + 1);
    return v[31:0];
  endfunction

  // one complete access with the memory answering after gd/rv cycles
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gd, input int rv, input logic [31:0] raw,
                            input string tag);
    int cz;
    int stalls;
    cz = ref_cause(rd, wr, int'(t), a);
    @(negedge CLK);
    valid_i      = 1'b1;
    mem_ctrl_i   = {wr, rd, 1'($urandom), t};
    addr_i       = a;
    store_data_i = d;
    dmem.gnt     = 1'b0;
    dmem.rvalid  = 1'b0;
    #1;
    chk({tag, ".stall_acc"}, 32'(stall_o), 32'(cz == 0));
    stalls = int'(stall_o);
    @(negedge CLK);
    valid_i      = 1'b0;
    mem_ctrl_i   = 6'($urandom);
    addr_i       = $urandom;
    store_data_i = $urandom;
    #1;
    if (cz != 0) begin
      chk({tag, ".fault"}, 32'(fault_o), 32'd1);
      chk({tag, ".cause"}, 32'(fault_cause_o), 32'(cz));
      chk({tag, ".noreq"}, 32'(dmem.req), 32'd0);
      chk({tag, ".nostall"}, 32'(stall_o), 32'd0);
      @(negedge CLK);
      #1;
      chk({tag, ".fault_pulse"}, 32'(fault_o), 32'd0);
      return;
    end
    chk({tag, ".we"}, 32'(dmem.we), 32'(wr));
    chk({tag, ".addr"}, dmem.addr, {a[31:2], 2'b00});
    if (wr) begin
      chk({tag, ".be"}, 32'(dmem.be), 32'(ref_be(int'(t), a)));
      chk({tag, ".wdata"}, dmem.wdata, ref_wdata(int'(t), d));
    end
    for (int w = 0; w <= gd; w++) begin
      if (w > 0) @(negedge CLK);
      dmem.gnt    = (w == gd);
      dmem.rvalid = (w == gd) ? (!wr && rv == 0) : (!wr && ($urandom % 2 == 1));
      dmem.rdata  = (w == gd) ? raw : $urandom;
      #1;
      chk({tag, ".req_held"}, 32'(dmem.req), 32'd1);
      stalls += int'(stall_o);
    end
    if (!wr) begin
      for (int k = 1; k <= rv; k++) begin
        @(negedge CLK);
        dmem.gnt    = 1'b0;
        dmem.rvalid = (k == rv);
        dmem.rdata  = (k == rv) ? raw : $urandom;
        #1;
        chk({tag, ".req_wait"}, 32'(dmem.req), 32'd0);
        stalls += int'(stall_o);
      end
    end
    @(negedge CLK);
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = $urandom;
    #1;
    chk({tag, ".stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(wr ? gd + 2 : gd + 2 + rv));
    chk({tag, ".req_done"}, 32'(dmem.req), 32'd0);
    chk({tag, ".lvalid"}, 32'(load_valid_o), 32'(!wr));
    if (!wr) chk({tag, ".ldata"}, load_data_o, ref_load(int'(t), a, raw));
    chk({tag, ".nofault"}, 32'(fault_o), 32'd0);
    @(negedge CLK);
    #1;
    chk({tag, ".lvalid_pulse"}, 32'(load_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    logic [2:0] t;
    logic [31:0] a;
    int k;

    RESET        = 1'b1;
    valid_i      = 1'b0;
    mem_ctrl_i   = 6'h0;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
    dmem.gnt     = 1'b0;
    dmem.rvalid  = 1'b0;
    dmem.rdata   = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst.req", 32'(dmem.req), 32'd0);
    chk("rst.we", 32'(dmem.we), 32'd0);
    chk("rst.addr", dmem.addr, 32'h0);
    chk("rst.be", 32'(dmem.be), 32'h0);
    chk("rst.wdata", dmem.wdata, 32'h0);
    chk("rst.lvalid", 32'(load_valid_o), 32'd0);
    chk("rst.ldata", load_data_o, 32'h0);
    chk("rst.fault", 32'(fault_o), 32'd0);
    chk("rst.cause", 32'(fault_cause_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    RESET = 1'b0;

    // live slot without read/write, and read without valid: no access
    @(negedge CLK);
    valid_i = 1'b1; mem_ctrl_i = 6'b001010; addr_i = 32'h40;
    #1;
    chk("noacc.stall", 32'(stall_o), 32'd0);
    @(negedge CLK);
    valid_i = 1'b0; mem_ctrl_i = 6'b010010;
    #1;
    chk("noacc.req", 32'(dmem.req), 32'd0);
    chk("novalid.stall", 32'(stall_o), 32'd0);

    run_access(0, 1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 0, "sw");
    run_access(0, 1, F3_SB, 32'h103, 32'h123456A5, 3, 0, 0, "sb");
    run_access(0, 1, F3_SH, 32'h202, 32'hCAFE8001, 1, 0, 0, "sh");
    run_access(1, 0, F3_LB, 32'h102, 32'h0, 0, 0, 32'h0080_0000, "lb");
    run_access(1, 0, F3_LBU, 32'h102, 32'h0, 0, 0, 32'h0080_0000, "lbu");
    run_access(1, 0, F3_LH, 32'h302, 32'h0, 2, 1, 32'h8001_7FFF, "lh");
    run_access(1, 0, F3_LHU, 32'h300, 32'h0, 0, 2, 32'h1234_F00D, "lhu");
    run_access(1, 0, F3_LH, 32'h101, 32'h0, 0, 0, 0, "lh_mis");
    run_access(1, 1, F3_LW, 32'h100, 32'h0, 0, 0, 0, "rdwr");
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 0, "t011");
    run_access(0, 1, F3_SW, 32'h106, 32'h1, 0, 0, 0, "sw_mis");
    run_access(1, 0, F3_LW, 32'h400, 32'h0, 0, MAXR - 1 > 4 ? 5 : 4, 32'h8765_4321, "lw_wait");

    // reset while waiting for read data
    @(negedge CLK);
    valid_i = 1'b1; mem_ctrl_i = {2'b01, 1'b0, F3_LW}; addr_i = 32'h200;
    @(negedge CLK);
    valid_i = 1'b0; dmem.gnt = 1'b1; dmem.rvalid = 1'b0;
    @(negedge CLK);
    dmem.gnt = 1'b0;
    #1;
    chk("rstw.in_wait", 32'(stall_o), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    dmem.rvalid = 1'b1; dmem.gnt = 1'b1; dmem.rdata = 32'h5555_AAAA;
    #1;
    chk("rstw.req", 32'(dmem.req), 32'd0);
    chk("rstw.stall", 32'(stall_o), 32'd0);
    chk("rstw.addr", dmem.addr, 32'h0);
    chk("rstw.cause", 32'(fault_cause_o), 32'd0);
    @(negedge CLK);
    dmem.rvalid = 1'b0; dmem.gnt = 1'b0;
    #1;
    chk("rstw.late_rvalid", 32'(load_valid_o), 32'd0);
    chk("rstw.idle", 32'(stall_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // grant never arrives: four wait cycles then timeout fault
    @(negedge CLK);
    valid_i = 1'b1; mem_ctrl_i = {2'b10, 1'b0, F3_SW}; addr_i = 32'h500;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      valid_i = 1'b0;
      #1;
      chk("to.req_held", 32'(dmem.req), 32'd1);
    end
    @(negedge CLK);
    #1;
    chk("to.fault", 32'(fault_o), 32'd1);
    chk("to.cause", 32'(fault_cause_o), 32'd3);
    chk("to.req", 32'(dmem.req), 32'd0);
    chk("to.stall", 32'(stall_o), 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      k  = $urandom % 10;
      rd = (k >= 4);
      wr = (k < 4) || (k == 9 && ($urandom % 3 == 0));
      if (wr && !rd) t = 3'($urandom % 3);
      else begin
        k = $urandom % 5;
        t = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      if ($urandom % 10 == 0) t = ($urandom % 2 == 0) ? 3'b011 : 3'(6 + $urandom % 2);
      a = $urandom;
      if ($urandom % 4 != 0) a = a & ~32'(nbytes(int'(t)) - 1);
      run_access(rd, wr, t, a, $urandom, int'($urandom_range(0, MAXG)),
                 int'($urandom_range(0, MAXR)), $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
